// File: rtl/mbus_tx_arbiter.sv
// mbus_tx_arbiter: shares one MBus TX port among NUM_REQ local requesters.
// Arbitration is per message. The arbiter sequences multi-word (pend) transfers
// and the TX_SUCC/TX_FAIL -> TX_RESP_ACK response handshake, and reports
// per-requester done/fail status.
//
// Ports
//   CLK, RESETn      clock; synchronous active-low reset
//   REQ_VALID[i]     requester i has a word ready (held until REQ_ACK[i])
//   REQ_ADDR/DATA    packed per-requester address/data, slice i = [W*(i+1)-1:W*i]
//   REQ_PEND[i]      more words follow in this message
//   REQ_PRIO[i]      requester asks for MBus priority arbitration
//   REQ_ACK[i]       pulse: word accepted by MBus
//   REQ_DONE[i]      pulse: message ended with TX_SUCC
//   REQ_FAIL[i]      pulse: message ended with TX_FAIL
//   TX_ADDR/DATA/PEND, TX_REQ, PRIORITY, TX_RESP_ACK   to MBus node
//   TX_ACK, TX_SUCC, TX_FAIL                           from MBus node
module mbus_tx_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                        CLK,
  input  logic                        RESETn,
  input  logic [NUM_REQ-1:0]          REQ_VALID,
  input  logic [NUM_REQ*ADDR_W-1:0]   REQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0]   REQ_DATA,
  input  logic [NUM_REQ-1:0]          REQ_PEND,
  input  logic [NUM_REQ-1:0]          REQ_PRIO,
  output logic [NUM_REQ-1:0]          REQ_ACK,
  output logic [NUM_REQ-1:0]          REQ_DONE,
  output logic [NUM_REQ-1:0]          REQ_FAIL,
  output logic [ADDR_W-1:0]           TX_ADDR,
  output logic [DATA_W-1:0]           TX_DATA,
  output logic                        TX_PEND,
  output logic                        TX_REQ,
  input  logic                        TX_ACK,
  output logic                        PRIORITY,
  input  logic                        TX_SUCC,
  input  logic                        TX_FAIL,
  output logic                        TX_RESP_ACK
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_ACKWAIT, S_NEXT, S_RESP, S_RESPACK
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr;
  logic [IDX_W-1:0]   r_g;

  logic [NUM_REQ-1:0] w_prio_req;
  logic [NUM_REQ-1:0] w_cand;
  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_g_next;
  logic [NUM_REQ-1:0] w_g_onehot;
  logic               w_abort;

  // (base + off) mod NUM_REQ, for off < NUM_REQ
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Priority requesters, when present, shadow all others
  assign w_prio_req = REQ_VALID & REQ_PRIO;
  assign w_cand     = (|w_prio_req) ? w_prio_req : REQ_VALID;

  // First candidate at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_cand[wrap_add(r_rr, k)]) begin
        w_found = 1'b1;
        w_pick  = wrap_add(r_rr, k);
      end
    end
  end

  assign w_g_next   = wrap_add(r_g, 1);
  assign w_g_onehot = NUM_REQ'(1) << r_g;
  // TX_FAIL during the word phase ends the message at once
  assign w_abort    = TX_FAIL && ((r_state == S_SEND) || (r_state == S_ACKWAIT) ||
                                  (r_state == S_NEXT));

  // Arbiter / message sequencer
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_g         <= '0;
      REQ_ACK     <= '0;
      REQ_DONE    <= '0;
      REQ_FAIL    <= '0;
      TX_ADDR     <= '0;
      TX_DATA     <= '0;
      TX_PEND     <= 1'b0;
      TX_REQ      <= 1'b0;
      PRIORITY    <= 1'b0;
      TX_RESP_ACK <= 1'b0;
    end else begin
      REQ_ACK  <= '0;
      REQ_DONE <= '0;
      REQ_FAIL <= '0;
      if (w_abort) begin
        // In-flight word is dropped without REQ_ACK, even if TX_ACK is also high
        TX_REQ      <= 1'b0;
        REQ_FAIL    <= w_g_onehot;
        TX_RESP_ACK <= 1'b1;
        r_state     <= S_RESPACK;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_found) begin
              r_g      <= w_pick;
              TX_ADDR  <= REQ_ADDR[32'(w_pick)*ADDR_W +: ADDR_W];
              TX_DATA  <= REQ_DATA[32'(w_pick)*DATA_W +: DATA_W];
              TX_PEND  <= REQ_PEND[w_pick];
              PRIORITY <= REQ_PRIO[w_pick];
              TX_REQ   <= 1'b1;
              r_state  <= S_SEND;
            end
          end
          S_SEND: begin
            if (TX_ACK) begin
              TX_REQ  <= 1'b0;
              REQ_ACK <= w_g_onehot;
              r_state <= S_ACKWAIT;
            end
          end
          S_ACKWAIT: begin
            if (!TX_ACK) r_state <= TX_PEND ? S_NEXT : S_RESP;
          end
          S_NEXT: begin
            // Grant is locked; PRIORITY keeps the value of the first word
            if (REQ_VALID[r_g]) begin
              TX_ADDR <= REQ_ADDR[32'(r_g)*ADDR_W +: ADDR_W];
              TX_DATA <= REQ_DATA[32'(r_g)*DATA_W +: DATA_W];
              TX_PEND <= REQ_PEND[r_g];
              TX_REQ  <= 1'b1;
              r_state <= S_SEND;
            end
          end
          S_RESP: begin
            if (TX_FAIL) begin
              REQ_FAIL    <= w_g_onehot;
              TX_RESP_ACK <= 1'b1;
              r_state     <= S_RESPACK;
            end else if (TX_SUCC) begin
              REQ_DONE    <= w_g_onehot;
              TX_RESP_ACK <= 1'b1;
              r_state     <= S_RESPACK;
            end
          end
          S_RESPACK: begin
            if (!TX_SUCC && !TX_FAIL) begin
              TX_RESP_ACK <= 1'b0;
              PRIORITY    <= 1'b0;
              r_rr        <= w_g_next;
              r_state     <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
